// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Brief    : RV32I instruction-fetch front end: PC generator, in-order imem
//            request/response tracking and a prefetch FIFO to IF/ID.
// Revision : 1.0
// ============================================================================
module fetch_queue #(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter int               MAX_OUT  = 2,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        redirect,
    input  logic [XLEN-1:0]             redirect_pc,
    output logic                        imem_req_valid,
    input  logic                        imem_req_ready,
    output logic [XLEN-1:0]             imem_req_addr,
    input  logic                        imem_rsp_valid,
    input  logic [31:0]                 imem_rsp_data,
    output logic                        id_valid,
    input  logic                        id_ready,
    output logic [31:0]                 id_instr,
    output logic [XLEN-1:0]             id_pc,
    output logic [$clog2(DEPTH+1)-1:0]  count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam int c_out_w = $clog2(MAX_OUT + 1);
    localparam int c_fl_w  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [c_fl_w-1:0] c_fl_last = c_fl_w'(MAX_OUT - 1);

    logic [XLEN-1:0]    r_fetch_pc;
    logic [31:0]        r_fifo_instr [DEPTH];
    logic [XLEN-1:0]    r_fifo_pc    [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic [c_out_w-1:0] r_outstanding;
    logic [c_out_w-1:0] r_discard;
    logic [XLEN-1:0]    r_fl_pc      [MAX_OUT];
    logic [c_fl_w-1:0]  r_fl_rd;
    logic [c_fl_w-1:0]  r_fl_wr;

    logic [31:0]        w_reserved;
    logic               w_issue;
    logic               w_rsp_take;
    logic               w_rsp_keep;
    logic               w_pop;
    logic [c_out_w-1:0] w_out_next;
    logic [c_cnt_w-1:0] w_count_next;
    logic [XLEN-1:0]    w_redirect_target;
    logic [c_fl_w-1:0]  w_fl_rd_next;
    logic [c_fl_w-1:0]  w_fl_wr_next;

    // Every outstanding request holds a FIFO slot, so responses never overflow.
    assign w_reserved     = 32'(r_count) + 32'(r_outstanding);
    assign imem_req_valid = enable & ~redirect & ~rst
                          & (w_reserved < 32'(DEPTH))
                          & (32'(r_outstanding) < 32'(MAX_OUT));
    assign imem_req_addr  = r_fetch_pc;

    assign w_issue    = imem_req_valid & imem_req_ready;
    assign w_rsp_take = imem_rsp_valid & (r_outstanding != '0);
    assign w_rsp_keep = w_rsp_take & (r_discard == '0) & ~redirect;
    assign w_pop      = id_valid & id_ready & enable & ~redirect;

    assign id_valid = (r_count != '0);
    assign id_instr = id_valid ? r_fifo_instr[r_rd_ptr] : '0;
    assign id_pc    = id_valid ? r_fifo_pc[r_rd_ptr]    : '0;
    assign count    = r_count;

    assign w_redirect_target = redirect_pc & ~XLEN'(3);
    assign w_fl_rd_next = (r_fl_rd == c_fl_last) ? '0 : r_fl_rd + 1'b1;
    assign w_fl_wr_next = (r_fl_wr == c_fl_last) ? '0 : r_fl_wr + 1'b1;

    always_comb begin
        w_out_next = r_outstanding;
        if (w_issue && !w_rsp_take) begin
            w_out_next = r_outstanding + 1'b1;
        end else if (!w_issue && w_rsp_take) begin
            w_out_next = r_outstanding - 1'b1;
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (w_rsp_keep && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (!w_rsp_keep && w_pop) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_fl_rd       <= '0;
            r_fl_wr       <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (w_issue) begin
                r_fl_pc[r_fl_wr] <= r_fetch_pc;
                r_fl_wr          <= w_fl_wr_next;
            end
            if (w_rsp_take) begin
                r_fl_rd <= w_fl_rd_next;
            end
            if (redirect) begin
                // Everything still in flight belongs to the abandoned path.
                r_fetch_pc <= w_redirect_target;
                r_discard  <= w_out_next;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
            end else begin
                if (w_issue) begin
                    r_fetch_pc <= r_fetch_pc + XLEN'(4);
                end
                if (w_rsp_take && (r_discard != '0)) begin
                    r_discard <= r_discard - 1'b1;
                end
                if (w_rsp_keep) begin
                    r_fifo_instr[r_wr_ptr] <= imem_rsp_data;
                    r_fifo_pc[r_wr_ptr]    <= r_fl_pc[r_fl_rd];
                    r_wr_ptr               <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                r_count <= w_count_next;
            end
        end
    end

    a_rsp_needs_request: assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid && (r_outstanding == '0)));

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Brief    : Self-checking bench for fetch_queue: queue-based reference model,
//            in-order variable-latency memory, directed and random phases.
// Revision : 1.0
// ============================================================================
module tb_fetch_queue;

    localparam int c_depth   = 4;
    localparam int c_max_out = 2;
    localparam int c_cw      = $clog2(c_depth + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b1;
    logic            enable = 1'b0;
    logic            redirect = 1'b0;
    logic [31:0]     redirect_pc = '0;
    logic            imem_req_valid;
    logic            imem_req_ready = 1'b0;
    logic [31:0]     imem_req_addr;
    logic            imem_rsp_valid = 1'b0;
    logic [31:0]     imem_rsp_data = '0;
    logic            id_valid;
    logic            id_ready = 1'b0;
    logic [31:0]     id_instr;
    logic [31:0]     id_pc;
    logic [c_cw-1:0] count;

    logic            wr_req_valid;
    logic [31:0]     wr_req_addr;
    logic            wr_id_valid;
    logic [31:0]     wr_id_instr;
    logic [31:0]     wr_id_pc;
    logic [c_cw-1:0] wr_count;

    fetch_queue #(.XLEN(32), .DEPTH(c_depth), .MAX_OUT(c_max_out), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .enable(enable), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc), .count(count)
    );

    // Second instance only to observe PC wraparound from the top of memory.
    fetch_queue #(.XLEN(32), .DEPTH(c_depth), .MAX_OUT(c_max_out), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .enable(1'b1), .redirect(1'b0), .redirect_pc(32'h0),
        .imem_req_valid(wr_req_valid), .imem_req_ready(1'b1), .imem_req_addr(wr_req_addr),
        .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
        .id_valid(wr_id_valid), .id_ready(1'b1), .id_instr(wr_id_instr), .id_pc(wr_id_pc), .count(wr_count)
    );

    typedef struct {
        int          due;
        logic [31:0] addr;
    } mreq_t;

    mreq_t       mem_q[$];
    int          last_due = 0;
    int          lat_lo = 1;
    int          lat_hi = 1;
    int          cyc = 0;

    logic [31:0] m_pc = '0;
    logic [63:0] m_fifo[$];
    logic [31:0] m_infl[$];
    int          m_discard = 0;
    bit          m_init = 1'b0;

    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] addr);
        return {addr[15:0], addr[31:16]} ^ 32'hC0DE_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance the model.
    task automatic step(input bit r, input bit en, input bit rd, input logic [31:0] rpc,
                        input bit rdy, input bit idr);
        bit          e_req_valid, e_id_valid, hs, keep;
        logic [31:0] e_instr, e_pc, rsp_pc;
        int          lat, due;
        @(negedge clk);
        rst = r; enable = en; redirect = rd; redirect_pc = rpc;
        imem_req_ready = rdy; id_ready = idr;
        if (!r && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(mem_q[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
        e_req_valid = en && !rd && !r && (m_fifo.size() + m_infl.size() < c_depth)
                      && (m_infl.size() < c_max_out);
        e_id_valid  = (m_fifo.size() != 0);
        e_instr     = e_id_valid ? m_fifo[0][63:32] : 32'h0;
        e_pc        = e_id_valid ? m_fifo[0][31:0]  : 32'h0;
        if (m_init) begin
            check("req_valid", 32'(imem_req_valid), 32'(e_req_valid));
            check("req_addr",  imem_req_addr, m_pc);
            check("id_valid",  32'(id_valid), 32'(e_id_valid));
            check("id_instr",  id_instr, e_instr);
            check("id_pc",     id_pc, e_pc);
            check("count",     32'(count), 32'(m_fifo.size()));
        end
        hs = e_req_valid && rdy;
        if (r) begin
            m_pc = 32'h0; m_fifo.delete(); m_infl.delete(); m_discard = 0;
            mem_q.delete(); last_due = cyc; m_init = 1'b1;
        end else begin
            keep   = 1'b0;
            rsp_pc = 32'h0;
            if (imem_rsp_valid) begin
                void'(mem_q.pop_front());
                rsp_pc = m_infl.pop_front();
                if (!rd) begin
                    if (m_discard > 0) m_discard--;
                    else keep = 1'b1;
                end
            end
            if (rd) begin
                m_fifo.delete();
                m_discard = m_infl.size();
                m_pc = rpc & ~32'h3;
            end else begin
                if (e_id_valid && idr && en) void'(m_fifo.pop_front());
                if (keep) m_fifo.push_back({imem_rsp_data, rsp_pc});
                if (hs) begin
                    m_infl.push_back(m_pc);
                    lat = $urandom_range(lat_hi, lat_lo);
                    due = cyc + lat;
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    mem_q.push_back('{due: due, addr: m_pc});
                    m_pc = m_pc + 32'h4;
                end
            end
        end
        cyc++;
    endtask

    initial begin
        logic [31:0] pcs[$];
        int          first_valid;
        int          resume_addr;
        bit          got3;

        // Reset and start at full speed with a 1-cycle memory.
        lat_lo = 1; lat_hi = 1;
        step(1, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 1, 1);
        check("rst_count", 32'(count), 32'h0);
        check("rst_id_valid", 32'(id_valid), 32'h0);
        check("rst_id_instr", id_instr, 32'h0);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_req_valid", 32'(imem_req_valid), 32'h0);
        first_valid = -1;
        for (int c = 0; c < 8; c++) begin
            step(0, 1, 0, 0, 1, 1);
            if (c == 0) begin
                check("start_addr0", imem_req_addr, 32'h0);
                check("wrap_addr0", wr_req_addr, 32'hFFFF_FFFC);
                check("wrap_valid0", 32'(wr_req_valid), 32'h1);
            end
            if (c == 1) begin
                check("start_addr1", imem_req_addr, 32'h4);
                check("wrap_addr1", wr_req_addr, 32'h0);
            end
            if (id_valid) begin
                if (first_valid < 0) first_valid = c;
                pcs.push_back(id_pc);
            end
            check("start_count_le1", 32'(count <= 1), 32'h1);
        end
        check("start_first_valid", 32'(first_valid), 32'h2);
        check("start_npcs", 32'(pcs.size()), 32'h6);
        if (pcs.size() >= 3) begin
            check("start_pc0", pcs[0], 32'h0);
            check("start_pc1", pcs[1], 32'h4);
            check("start_pc2", pcs[2], 32'h8);
        end

        // Stall fill, then drain in order and resume fetching.
        step(1, 0, 0, 0, 1, 1);
        for (int c = 0; c < 10; c++) step(0, 1, 0, 0, 1, 0);
        check("fill_count", 32'(count), 32'h4);
        check("fill_req_valid", 32'(imem_req_valid), 32'h0);
        pcs.delete();
        resume_addr = -1;
        for (int c = 0; c < 4; c++) begin
            step(0, 1, 0, 0, 1, 1);
            pcs.push_back(id_pc);
            if (imem_req_valid && resume_addr < 0) resume_addr = imem_req_addr;
        end
        check("drain_pc0", pcs[0], 32'h0);
        check("drain_pc1", pcs[1], 32'h4);
        check("drain_pc2", pcs[2], 32'h8);
        check("drain_pc3", pcs[3], 32'hC);
        check("resume_addr", 32'(resume_addr), 32'h10);

        // Redirect with two requests in flight on a 3-cycle memory.
        lat_lo = 3; lat_hi = 3;
        step(1, 0, 0, 0, 1, 1);
        step(0, 1, 0, 0, 1, 1);
        step(0, 1, 0, 0, 1, 1);
        step(0, 1, 1, 32'h100, 1, 1);
        step(0, 1, 0, 0, 1, 1);
        check("redir_count", 32'(count), 32'h0);
        pcs.delete();
        for (int c = 0; c < 20 && pcs.size() < 2; c++) begin
            step(0, 1, 0, 0, 1, 1);
            if (id_valid) pcs.push_back(id_pc);
        end
        check("redir_npcs", 32'(pcs.size()), 32'h2);
        if (pcs.size() == 2) begin
            check("redir_pc0", pcs[0], 32'h100);
            check("redir_pc1", pcs[1], 32'h104);
        end

        // Redirect in the same cycle as a response.
        lat_lo = 1; lat_hi = 1;
        step(1, 0, 0, 0, 1, 1);
        step(0, 1, 0, 0, 1, 1);
        step(0, 1, 1, 32'h203, 1, 1);
        check("collide_rsp", 32'(imem_rsp_valid), 32'h1);
        step(0, 1, 0, 0, 1, 1);
        check("collide_addr", imem_req_addr, 32'h200);
        check("collide_id_valid", 32'(id_valid), 32'h0);

        // Enable freeze with responses in flight.
        lat_lo = 3; lat_hi = 3;
        step(1, 0, 0, 0, 1, 1);
        step(0, 1, 0, 0, 1, 1);
        step(0, 1, 0, 0, 1, 1);
        for (int c = 0; c < 5; c++) begin
            step(0, 0, 0, 0, 1, 1);
            check("freeze_req_valid", 32'(imem_req_valid), 32'h0);
        end
        check("freeze_count", 32'(count), 32'h2);
        check("freeze_pc", imem_req_addr, 32'h8);

        // Mid-operation reset with three entries queued.
        lat_lo = 1; lat_hi = 1;
        step(1, 0, 0, 0, 1, 1);
        got3 = 1'b0;
        for (int c = 0; c < 20 && !got3; c++) begin
            step(0, 1, 0, 0, 1, 0);
            if (count == 3) got3 = 1'b1;
        end
        check("midrst_fill3", 32'(got3), 32'h1);
        step(1, 1, 0, 0, 1, 0);
        step(0, 1, 0, 0, 1, 0);
        check("midrst_count", 32'(count), 32'h0);
        check("midrst_id_valid", 32'(id_valid), 32'h0);
        check("midrst_addr", imem_req_addr, 32'h0);

        // Randomised traffic against the model.
        lat_lo = 1; lat_hi = 4;
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 99) < 85,
                 $urandom_range(0, 99) < 5,
                 $urandom,
                 $urandom_range(0, 99) < 70,
                 $urandom_range(0, 99) < 70);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
